pipe_int_ctrl: RTL and testbench

PIPE_INT_CTRL -- requirements
Module: pipe_int_ctrl

---
 rtl/pipe_int_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_pipe_int_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_int_ctrl.sv
// pipe_int_ctrl: nested, fixed-priority interrupt controller for an in-order
// pipeline. Captures request edges, decides when to redirect fetch to a
// handler vector, and keeps a return stack so eret resumes the interrupted
// code.
//
// Redirect protocol: take and ret are single-cycle strobes with no
// back-pressure. vec_addr is valid only while take=1 and ret_addr only while
// ret=1; both read as zero at all other times. Each strobe is accompanied by
// flush_fd/flush_de/flush_em in the same cycle, and the controller accepts no
// new take or eret during that strobe cycle.
module pipe_int_ctrl #(
  parameter int          NUM_IRQ    = 4,
  parameter int          PC_W       = 32,
  parameter int          NEST_DEPTH = 4,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h10,
  localparam int         IW         = $clog2(NUM_IRQ),
  localparam int         DW         = $clog2(NEST_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               in_RST,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_data,
  input  logic               gie,
  input  logic [PC_W-1:0]    wb_pc,
  input  logic               eret,
  output logic               take,
  output logic [PC_W-1:0]    vec_addr,
  output logic               ret,
  output logic [PC_W-1:0]    ret_addr,
  output logic               flush_fd,
  output logic               flush_de,
  output logic               flush_em,
  output logic [NUM_IRQ-1:0] pending,
  output logic               in_service,
  output logic [IW-1:0]      cur_id,
  output logic [DW-1:0]      depth,
  output logic               err_eret,
  output logic [1:0]         dbg_state
);

  // Stack index width; a one-entry stack still needs a 1-bit index.
  localparam int SW = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1;

  // IDLE: nothing in service (depth 0). SERVE: inside a handler (depth > 0).
  // ENTER/EXIT: the one-cycle redirect strobes.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ENTER = 2'd2,
    ST_EXIT  = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next_state;

  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [IW-1:0]      r_cur_id;
  logic               r_in_service;
  logic [DW-1:0]      r_depth;
  logic               r_err_eret;
  logic               r_take;
  logic               r_ret;
  logic               r_flush;
  logic [PC_W-1:0]    r_vec_addr;
  logic [PC_W-1:0]    r_ret_addr;

  // Return stack: one frame per nesting level.
  logic [PC_W-1:0]    r_stk_pc  [NEST_DEPTH];
  logic [IW-1:0]      r_stk_id  [NEST_DEPTH];
  logic               r_stk_svc [NEST_DEPTH];

  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_elig;
  logic [NUM_IRQ-1:0] w_clr;
  logic               w_accept;
  logic               w_room;
  logic               w_eret_ok;
  logic               w_eret_bad;
  logic               w_take_now;
  logic [IW-1:0]      w_win;
  logic [PC_W-1:0]    w_vec;
  logic [SW-1:0]      w_push_idx;
  logic [SW-1:0]      w_pop_idx;

  // Rising edges on the raw lines; these set pending regardless of en/mask.
  assign w_edge = irq_in & ~r_irq_prev;

  // Decisions are only taken in the resting states and while the pipe runs.
  assign w_accept   = en & ((r_state == ST_IDLE) | (r_state == ST_SERVE));
  assign w_eret_ok  = w_accept & eret & (r_state == ST_SERVE);
  assign w_eret_bad = w_accept & eret & (r_state == ST_IDLE);
  assign w_room     = (r_depth < DW'(NEST_DEPTH));

  assign w_push_idx = SW'(r_depth);
  assign w_pop_idx  = SW'(r_depth - DW'(1));

  // Per-channel eligibility: an eret in the same cycle suppresses all takes,
  // and while nested only a strictly higher channel may preempt.
  always_comb begin
    w_elig = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      w_elig[i] = r_pending[i] & r_mask[i] & gie & w_accept & ~eret & w_room &
                  ((r_depth == '0) | (i > int'(r_cur_id)));
    end
  end

  // Fixed priority: scanning upward, the last eligible index seen wins.
  always_comb begin
    w_win      = '0;
    w_take_now = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (w_elig[i]) begin
        w_win      = IW'(i);
        w_take_now = 1'b1;
      end
    end
  end

  // Handler address of the winning channel, wrapped to PC width.
  assign w_vec = PC_W'(VEC_BASE) + PC_W'(VEC_STRIDE) * PC_W'(w_win);

  // Pending bit of the channel being taken is cleared this cycle.
  assign w_clr = w_take_now ? (NUM_IRQ'(1) << w_win) : '0;

  // Next-state selection; eret is checked before takes in SERVE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take_now) w_next_state = ST_ENTER;
      end
      ST_SERVE: begin
        if (w_eret_ok)       w_next_state = ST_EXIT;
        else if (w_take_now) w_next_state = ST_ENTER;
      end
      ST_ENTER: w_next_state = ST_SERVE;
      ST_EXIT:  w_next_state = (r_depth != '0) ? ST_SERVE : ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (in_RST) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // Request capture, mask register and the sticky stray-eret flag.
  always_ff @(posedge clk) begin
    if (in_RST) begin
      r_irq_prev <= '0;
      r_pending  <= '0;
      r_mask     <= '0;
      r_err_eret <= 1'b0;
    end else begin
      r_irq_prev <= irq_in;
      r_pending  <= (r_pending & ~w_clr) | w_edge;
      if (mask_wr)    r_mask     <= mask_data;
      if (w_eret_bad) r_err_eret <= 1'b1;
    end
  end

  // Registered redirect strobes; addresses are zero outside their strobe.
  always_ff @(posedge clk) begin
    if (in_RST) begin
      r_take     <= 1'b0;
      r_ret      <= 1'b0;
      r_flush    <= 1'b0;
      r_vec_addr <= '0;
      r_ret_addr <= '0;
    end else begin
      r_take     <= w_take_now;
      r_ret      <= w_eret_ok;
      r_flush    <= w_take_now | w_eret_ok;
      r_vec_addr <= w_take_now ? w_vec : '0;
      r_ret_addr <= w_eret_ok ? r_stk_pc[w_pop_idx] : '0;
    end
  end

  // Nesting context: push on take, pop and restore on eret.
  always_ff @(posedge clk) begin
    if (in_RST) begin
      r_cur_id     <= '0;
      r_in_service <= 1'b0;
      r_depth      <= '0;
      for (int k = 0; k < NEST_DEPTH; k++) begin
        r_stk_pc[k]  <= '0;
        r_stk_id[k]  <= '0;
        r_stk_svc[k] <= 1'b0;
      end
    end else if (w_take_now) begin
      r_stk_pc[w_push_idx]  <= wb_pc;
      r_stk_id[w_push_idx]  <= r_cur_id;
      r_stk_svc[w_push_idx] <= r_in_service;
      r_cur_id              <= w_win;
      r_in_service          <= 1'b1;
      r_depth               <= r_depth + DW'(1);
    end else if (w_eret_ok) begin
      r_cur_id     <= r_stk_id[w_pop_idx];
      r_in_service <= r_stk_svc[w_pop_idx];
      r_depth      <= r_depth - DW'(1);
    end
  end

  assign take       = r_take;
  assign ret        = r_ret;
  assign vec_addr   = r_vec_addr;
  assign ret_addr   = r_ret_addr;
  assign flush_fd   = r_flush;
  assign flush_de   = r_flush;
  assign flush_em   = r_flush;
  assign pending    = r_pending;
  assign in_service = r_in_service;
  assign cur_id     = r_cur_id;
  assign depth      = r_depth;
  assign err_eret   = r_err_eret;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pipe_int_ctrl.sv
// Bench for pipe_int_ctrl: directed vector table, hand-written nesting
// sequences and a randomized run, all checked cycle by cycle against a
// behavioural model built on a frame queue.
module tb_pipe_int_ctrl;

  localparam int          NI = 4;
  localparam int          PW = 32;
  localparam int          ND = 2;
  localparam logic [31:0] VB = 32'h100;
  localparam logic [31:0] VS = 32'h10;
  localparam int          BW = 79;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          in_RST = 1'b1;
  logic          en = 1'b0;
  logic [NI-1:0] irq_in = '0;
  logic          mask_wr = 1'b0;
  logic [NI-1:0] mask_data = '0;
  logic          gie = 1'b0;
  logic [PW-1:0] wb_pc = '0;
  logic          eret = 1'b0;
  logic          take, ret, flush_fd, flush_de, flush_em, in_service, err_eret;
  logic [PW-1:0] vec_addr, ret_addr;
  logic [NI-1:0] pending;
  logic [1:0]    cur_id, depth, dbg_state;

  always #5 clk = ~clk;

  pipe_int_ctrl #(
    .NUM_IRQ(NI), .PC_W(PW), .NEST_DEPTH(ND), .VEC_BASE(VB), .VEC_STRIDE(VS)
  ) dut (
    .clk(clk), .in_RST(in_RST), .en(en), .irq_in(irq_in),
    .mask_wr(mask_wr), .mask_data(mask_data), .gie(gie), .wb_pc(wb_pc),
    .eret(eret), .take(take), .vec_addr(vec_addr), .ret(ret),
    .ret_addr(ret_addr), .flush_fd(flush_fd), .flush_de(flush_de),
    .flush_em(flush_em), .pending(pending), .in_service(in_service),
    .cur_id(cur_id), .depth(depth), .err_eret(err_eret),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  logic [32:0] exp_q[$];   // {is_ret, address} of each expected redirect

  task automatic check(input string nm, input logic [BW-1:0] act,
                       input logic [BW-1:0] exp_v);
    n_total++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  function automatic logic [BW-1:0] pack(
    input logic tk, input logic rt, input logic fl,
    input logic [31:0] va, input logic [31:0] ra, input logic [3:0] pd,
    input logic sv, input logic [1:0] cu, input logic [1:0] dp,
    input logic er);
    return {tk, rt, fl, fl, fl, va, ra, pd, sv, cu, dp, er};
  endfunction

  function automatic logic [BW-1:0] dut_bundle();
    return {take, ret, flush_fd, flush_de, flush_em, vec_addr, ret_addr,
            pending, in_service, cur_id, depth, err_eret};
  endfunction

  // ---------------- behavioural reference model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  id;
    logic        svc;
  } frame_t;

  frame_t      m_stk[$];
  logic [3:0]  m_pend = '0, m_mask = '0, m_prev = '0;
  logic [1:0]  m_cur = '0;
  logic        m_svc = 1'b0, m_err = 1'b0, m_busy = 1'b0;
  logic        m_take = 1'b0, m_ret = 1'b0;
  logic [31:0] m_vec = '0, m_raddr = '0;

  // One clock of the model, using the inputs currently applied.
  task automatic model_step();
    bit     do_take, do_ret;
    int     win;
    frame_t f;
    if (in_RST) begin
      m_pend = '0; m_mask = '0; m_prev = '0; m_stk.delete();
      m_cur = '0; m_svc = 1'b0; m_err = 1'b0; m_busy = 1'b0;
      m_take = 1'b0; m_ret = 1'b0; m_vec = '0; m_raddr = '0;
      return;
    end
    do_take = 0; do_ret = 0; win = 0;
    if (!m_busy && en) begin
      if (eret) begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else                   do_ret = 1;
      end else if (gie && m_stk.size() < ND) begin
        for (int i = 0; i < NI; i++)
          if (m_pend[i] && m_mask[i] && (m_stk.size() == 0 || i > int'(m_cur))) begin
            do_take = 1; win = i;
          end
      end
    end
    m_vec = '0; m_raddr = '0;
    if (do_take) begin
      m_stk.push_back('{pc: wb_pc, id: m_cur, svc: m_svc});
      m_cur = 2'(win); m_svc = 1'b1; m_pend[win] = 1'b0;
      m_vec = VB + VS * 32'(win);
      exp_q.push_back({1'b0, m_vec});
    end
    if (do_ret) begin
      f = m_stk.pop_back();
      m_cur = f.id; m_svc = f.svc; m_raddr = f.pc;
      exp_q.push_back({1'b1, f.pc});
    end
    m_pend = m_pend | (irq_in & ~m_prev);
    m_prev = irq_in;
    if (mask_wr) m_mask = mask_data;
    m_busy = do_take || do_ret;
    m_take = do_take; m_ret = do_ret;
  endtask

  function automatic logic [BW-1:0] model_bundle();
    return pack(m_take, m_ret, m_take | m_ret, m_vec, m_raddr, m_pend, m_svc,
                m_cur, 2'(m_stk.size()), m_err);
  endfunction

  // ---------------- driver tasks ----------------
  // Apply one cycle of inputs, step the model, compare after the edge.
  task automatic cyc(input logic [3:0] irq_v, input logic eret_v,
                     input logic [31:0] pc_v);
    logic [32:0] e;
    irq_in = irq_v; eret = eret_v; wb_pc = pc_v;
    model_step();
    @(posedge clk);
    #1;
    check("cycle", dut_bundle(), model_bundle());
    if (take || ret) begin
      if (exp_q.size() == 0) begin
        n_total++; n_bad++;
        $display("FAIL sb_event: got=%h want=none", {ret, ret ? ret_addr : vec_addr});
      end else begin
        e = exp_q.pop_front();
        check("sb_event", BW'({ret, ret ? ret_addr : vec_addr}), BW'(e));
      end
    end
  endtask

  task automatic do_reset();
    in_RST = 1'b1; en = 1'b1; gie = 1'b1; mask_wr = 1'b0;
    cyc(4'b0, 1'b0, 32'h0);
    in_RST = 1'b0;
  endtask

  task automatic set_mask(input logic [3:0] m);
    mask_wr = 1'b1; mask_data = m;
    cyc(4'b0, 1'b0, 32'h0);
    mask_wr = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, en_v, gie_v, mwr, eret_v;
    logic [3:0]  irq, mdata;
    logic [31:0] pc;
    logic [BW-1:0] exp_v;
  } vec_t;

  vec_t tbl[10];
  logic [3:0] rnd_irq;

  initial begin
    // rst en gie mwr eret irq mdata pc ; expected outputs after the edge
    tbl[0] = '{1,1,1,0,0, 4'b0000, 4'b0000, 32'h0,  pack(0,0,0, 0, 0, 4'b0000, 0, 0, 0, 0)};
    tbl[1] = '{0,1,1,1,0, 4'b0000, 4'b0100, 32'h0,  pack(0,0,0, 0, 0, 4'b0000, 0, 0, 0, 0)};
    tbl[2] = '{0,1,1,0,0, 4'b0100, 4'b0000, 32'h0,  pack(0,0,0, 0, 0, 4'b0100, 0, 0, 0, 0)};
    tbl[3] = '{0,1,1,0,0, 4'b0100, 4'b0000, 32'h40, pack(1,0,1, 32'h120, 0, 4'b0000, 1, 2, 1, 0)};
    tbl[4] = '{0,1,1,0,0, 4'b0000, 4'b0000, 32'h44, pack(0,0,0, 0, 0, 4'b0000, 1, 2, 1, 0)};
    tbl[5] = '{0,1,1,0,1, 4'b0000, 4'b0000, 32'h48, pack(0,1,1, 0, 32'h40, 4'b0000, 0, 0, 0, 0)};
    tbl[6] = '{0,1,1,0,0, 4'b0000, 4'b0000, 32'h4c, pack(0,0,0, 0, 0, 4'b0000, 0, 0, 0, 0)};
    tbl[7] = '{0,1,1,0,1, 4'b0000, 4'b0000, 32'h50, pack(0,0,0, 0, 0, 4'b0000, 0, 0, 0, 1)};
    tbl[8] = '{0,1,1,0,0, 4'b0000, 4'b0000, 32'h54, pack(0,0,0, 0, 0, 4'b0000, 0, 0, 0, 1)};
    tbl[9] = '{1,1,1,0,0, 4'b0000, 4'b0000, 32'h0,  pack(0,0,0, 0, 0, 4'b0000, 0, 0, 0, 0)};

    for (int i = 0; i < 10; i++) begin
      in_RST = tbl[i].rst; en = tbl[i].en_v; gie = tbl[i].gie_v;
      mask_wr = tbl[i].mwr; mask_data = tbl[i].mdata;
      cyc(tbl[i].irq, tbl[i].eret_v, tbl[i].pc);
      check($sformatf("row%0d", i), dut_bundle(), tbl[i].exp_v);
    end

    // Nesting: 3 preempts 1, 0 stays pending, eret resumes into channel 1.
    do_reset(); set_mask(4'b1111);
    cyc(4'b0010, 0, 32'h10);
    cyc(4'b0010, 0, 32'h14);
    cyc(4'b0000, 0, 32'h18);
    cyc(4'b1000, 0, 32'h20);
    cyc(4'b1000, 0, 32'h24);
    check("s37_take", BW'(take), BW'(1));
    check("s37_vec", BW'(vec_addr), BW'(32'h130));
    check("s37_depth", BW'(depth), BW'(2));
    cyc(4'b1001, 0, 32'h28);
    cyc(4'b0000, 0, 32'h2c);
    check("s37_pend0", BW'(pending), BW'(4'b0001));
    cyc(4'b0000, 1, 32'h30);
    check("s37_raddr", BW'(ret_addr), BW'(32'h24));
    check("s37_cur", BW'(cur_id), BW'(1));
    cyc(4'b0000, 0, 32'h34);
    cyc(4'b0000, 1, 32'h38);
    cyc(4'b0000, 0, 32'h3c);
    cyc(4'b0000, 0, 32'h40);
    check("s37_take0", BW'(vec_addr), BW'(32'h100));
    cyc(4'b0000, 0, 32'h44);
    cyc(4'b0000, 1, 32'h48);
    cyc(4'b0000, 0, 32'h4c);

    // Full stack holds channel 3 until an eret frees a level.
    do_reset(); set_mask(4'b1111);
    cyc(4'b0010, 0, 32'h100);
    cyc(4'b0010, 0, 32'h104);
    cyc(4'b0000, 0, 32'h108);
    cyc(4'b0100, 0, 32'h10c);
    cyc(4'b0100, 0, 32'h110);
    cyc(4'b0000, 0, 32'h114);
    cyc(4'b1000, 0, 32'h118);
    cyc(4'b1000, 0, 32'h11c);
    cyc(4'b1000, 0, 32'h120);
    check("s38_held", BW'({take, pending, depth}), BW'({1'b0, 4'b1000, 2'd2}));
    cyc(4'b0000, 1, 32'h124);
    check("s38_ret", BW'({ret, ret_addr}), BW'({1'b1, 32'h110}));
    cyc(4'b0000, 0, 32'h128);
    cyc(4'b0000, 0, 32'h12c);
    check("s38_take3", BW'({take, vec_addr, depth}), BW'({1'b1, 32'h130, 2'd2}));
    cyc(4'b0000, 0, 32'h130);
    cyc(4'b0000, 1, 32'h134);
    cyc(4'b0000, 0, 32'h138);
    cyc(4'b0000, 1, 32'h13c);
    cyc(4'b0000, 0, 32'h140);

    // eret and an eligible channel together: EXIT first, take afterwards.
    do_reset(); set_mask(4'b1111);
    cyc(4'b0010, 0, 32'h200);
    cyc(4'b0010, 0, 32'h204);
    cyc(4'b0000, 0, 32'h208);
    cyc(4'b1000, 0, 32'h20c);
    cyc(4'b1000, 1, 32'h210);
    check("s39_exit", BW'({ret, take, pending}), BW'({1'b1, 1'b0, 4'b1000}));
    cyc(4'b1000, 0, 32'h214);
    check("s39_gap", BW'(take), BW'(0));
    cyc(4'b1000, 0, 32'h218);
    check("s39_take", BW'({take, vec_addr, depth}), BW'({1'b1, 32'h130, 2'd1}));
    cyc(4'b0000, 0, 32'h21c);
    cyc(4'b0000, 1, 32'h220);
    cyc(4'b0000, 0, 32'h224);

    // Stall blocks takes; reset mid-ENTER; line held high through reset.
    do_reset(); set_mask(4'b1111);
    en = 1'b0;
    cyc(4'b0100, 0, 32'h300);
    cyc(4'b0100, 0, 32'h304);
    cyc(4'b0000, 0, 32'h308);
    check("s40_stall", BW'({take, pending}), BW'({1'b0, 4'b0100}));
    cyc(4'b0001, 0, 32'h30c);
    check("s40_edge", BW'(pending), BW'(4'b0101));
    en = 1'b1;
    cyc(4'b0000, 0, 32'h310);
    check("s40_take", BW'({take, vec_addr}), BW'({1'b1, 32'h120}));
    in_RST = 1'b1;
    cyc(4'b0010, 0, 32'h314);
    check("s40_rst", dut_bundle(), pack(0,0,0, 0, 0, 4'b0000, 0, 0, 0, 0));
    in_RST = 1'b0;
    cyc(4'b0010, 0, 32'h318);
    check("s40_held", BW'(pending), BW'(4'b0010));

    // Randomized run against the model.
    do_reset(); set_mask(4'b1111);
    rnd_irq = '0;
    for (int n = 0; n < 3000; n++) begin
      in_RST    = ($urandom_range(0, 399) == 0);
      en        = ($urandom_range(0, 7) != 0);
      gie       = ($urandom_range(0, 15) != 0);
      mask_wr   = ($urandom_range(0, 31) == 0);
      mask_data = 4'($urandom_range(0, 15));
      for (int b = 0; b < NI; b++)
        if ($urandom_range(0, 5) == 0) rnd_irq[b] = ~rnd_irq[b];
      cyc(rnd_irq, ($urandom_range(0, 7) == 0), $urandom);
    end

    check("sb_drain", BW'(exp_q.size()), BW'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
